// File: rtl/on_chip_mem_reader.sv
// on_chip_mem_reader: streams a wrap-around window of sample RAM over valid/ready through a credit-managed skid FIFO.
// Define MEM_READER_DECIMATE_EN to add the decim address-step port.
module on_chip_mem_reader #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 10001,
  parameter int RD_LATENCY  = 2,
  parameter int NUM_SAMPLES = 640
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
`ifdef MEM_READER_DECIMATE_EN
  input  logic [3:0]        decim,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_cs,
  output logic              mem_clk_en,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              sample_last
);
  localparam int FD = RD_LATENCY + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] issued, handshakes;
  logic [RD_LATENCY-1:0] pipe;
  logic [DATA_W-1:0] fifo [FD];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] fifo_cnt;
  logic issue, push, pop;
  logic [ADDR_W-1:0] step, first_addr, addr_nx;
  logic [ADDR_W:0] addr_sum;
`ifdef MEM_READER_DECIMATE_EN
  logic [3:0] decim_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) decim_q <= 4'd1;
    else if (state == IDLE && start) decim_q <= (decim == 4'd0) ? 4'd1 : decim;
  assign step = ADDR_W'(decim_q);
`else
  assign step = ADDR_W'(1);
`endif
  always_comb begin
    busy         = state == READ || state == DRAIN;
    done         = state == DONE;
    mem_cs       = busy;
    mem_clk_en   = 1'b1;
    sample_valid = fifo_cnt != '0;
    sample_data  = fifo[rd_ptr];
    sample_last  = sample_valid && handshakes == CW'(NUM_SAMPLES - 1);
    pop          = sample_valid && sample_ready;
    push         = pipe[RD_LATENCY-1];
    // credit: never more reads outstanding than the FIFO can absorb
    issue        = state == READ && ($countones(pipe) + int'(fifo_cnt)) < FD;
    first_addr   = (start_addr >= ADDR_W'(DEPTH)) ? '0 : start_addr;
    addr_sum     = {1'b0, mem_address} + {1'b0, step};
    addr_nx      = (addr_sum >= (ADDR_W+1)'(DEPTH)) ? ADDR_W'(addr_sum - (ADDR_W+1)'(DEPTH)) : addr_sum[ADDR_W-1:0];
    state_nx     = (state == IDLE && start) ? READ :
                   (state == READ && issue && issued == CW'(NUM_SAMPLES - 1)) ? DRAIN :
                   (state == DRAIN && pop && sample_last) ? DONE :
                   (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      mem_address <= '0;
      issued      <= '0;
      handshakes  <= '0;
      pipe        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      for (int i = 0; i < FD; i++) fifo[i] <= '0;
    end else begin
      state <= state_nx;
      pipe  <= RD_LATENCY'({pipe, issue});
      if (state == IDLE && start) begin
        mem_address <= first_addr;
        issued      <= '0;
        handshakes  <= '0;
      end else begin
        if (issue) begin
          mem_address <= addr_nx;
          issued      <= issued + CW'(1);
        end
        if (pop) handshakes <= handshakes + CW'(1);
      end
      if (push) begin
        fifo[wr_ptr] <= mem_read_data;
        wr_ptr       <= (wr_ptr == PW'(FD - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FD - 1)) ? '0 : rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: tb/tb_on_chip_mem_reader.sv
// tb_on_chip_mem_reader: table-driven windows with a data scoreboard plus start-poke and mid-window reset sequences.
module tb_on_chip_mem_reader;
  localparam int AW = 17, DW = 8, DEPTH = 10001, LAT = 2, NS = 640;
  logic clk = 0, reset_n = 0, start = 0, sample_ready = 0;
  logic [AW-1:0] start_addr = '0;
  logic busy, done, mem_cs, mem_clk_en, sample_valid, sample_last;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_read_data, sample_data, r1;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] seen [$];
  int checks = 0, errors = 0;
  typedef struct { logic [AW-1:0] sa; logic [AW-1:0] first; int pct; } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  on_chip_mem_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
`ifdef MEM_READER_DECIMATE_EN
    .decim(4'd1),
`endif
    .busy(busy), .done(done), .mem_address(mem_address), .mem_cs(mem_cs),
    .mem_clk_en(mem_clk_en), .mem_read_data(mem_read_data), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_last(sample_last)
  );

  // two-stage registered RAM read path
  always @(posedge clk) begin
    r1 <= (int'(mem_address) < DEPTH) ? ram[mem_address] : 8'hEE;
    mem_read_data <= r1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_last", sample_last, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_clk_en", mem_clk_en, 1);
  endtask

  task automatic run_window(input logic [AW-1:0] sa, input logic [AW-1:0] first, input int pct,
                            input bit poke, input int rst_at);
    int n, got, first_v, done_cnt, done_n, last_n, bubbles, addr_err, maxocc;
    bit prev_stall;
    logic [DW-1:0] prev_d, e;
    logic [AW-1:0] a;
    exp_q.delete();
    seen.delete();
    a = first;
    for (int i = 0; i < NS; i++) begin
      exp_q.push_back(ram[a]);
      a = (int'(a) + 1 == DEPTH) ? '0 : a + 1'b1;
    end
    n = 1; got = 0; first_v = -1; done_cnt = 0; done_n = -1; last_n = -1; bubbles = 0; maxocc = 0;
    prev_stall = 0; prev_d = '0;
    @(negedge clk);
    start = 1;
    start_addr = sa;
    @(negedge clk);
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_cs", mem_cs, 1);
    chk("start_addr", mem_address, first);
    while (n < 20000) begin
      sample_ready = ($urandom_range(99) < pct);
      start = poke && (n == 50 || done);
      if (dut.issue) seen.push_back(mem_address);
      if (int'(dut.fifo_cnt) > maxocc) maxocc = int'(dut.fifo_cnt);
      if (prev_stall) begin
        chk("hold_valid", sample_valid, 1);
        chk("hold_data", sample_data, prev_d);
      end
      if (sample_valid && first_v < 0) first_v = n;
      if (pct == 100 && got > 0 && got < NS && !sample_valid) bubbles++;
      if (done) begin
        done_cnt++;
        done_n = n;
        chk("busy_at_done", busy, 0);
      end
      if (got == NS && n > last_n + 1) chk("idle_after_done", busy, 0);
      prev_stall = sample_valid && !sample_ready;
      prev_d = sample_data;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) chk("extra_sample", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sample_data", sample_data, e);
          chk("sample_last", sample_last, (got == NS - 1) ? 1 : 0);
        end
        got++;
        if (got == NS) last_n = n;
      end
      if (rst_at >= 0 && got == rst_at) break;
      if (got == NS && n > last_n + 3) break;
      @(negedge clk);
      n++;
    end
    start = 0;
    if (rst_at >= 0) begin
      reset_n = 0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      reset_n = 1;
      repeat (20) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      chk("rst_no_done", done_cnt, 0);
      chk("rst_idle", busy, 0);
      chk("rst_valid_after", sample_valid, 0);
      return;
    end
    chk("sample_count", got, NS);
    chk("first_valid_cycle", first_v, LAT + 2);
    chk("done_pulses", done_cnt, 1);
    chk("done_timing", done_n, last_n + 1);
    if (pct == 100) chk("bubbles", bubbles, 0);
    chk("fifo_occ_le_4", (maxocc <= LAT + 2) ? 1 : 0, 1);
    chk("issue_count", seen.size(), NS);
    a = first;
    addr_err = 0;
    foreach (seen[i]) begin
      if (seen[i] !== a || int'(seen[i]) >= DEPTH) addr_err++;
      a = (int'(a) + 1 == DEPTH) ? '0 : a + 1'b1;
    end
    chk("addr_seq", addr_err, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 37 + (i >> 7));
    vecs[0] = '{sa: 17'd100,   first: 17'd100,   pct: 100};
    vecs[1] = '{sa: 17'd9800,  first: 17'd9800,  pct: 100};
    vecs[2] = '{sa: 17'd5000,  first: 17'd5000,  pct: 30};
    vecs[3] = '{sa: 17'd12000, first: 17'd0,     pct: 100};
    vecs[4] = '{sa: 17'd10000, first: 17'd10000, pct: 60};
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset_n = 1;
    repeat (2) @(negedge clk);
    for (int v = 0; v < 5; v++) run_window(vecs[v].sa, vecs[v].first, vecs[v].pct, 0, -1);
    run_window(17'd2000, 17'd2000, 100, 1, -1);
    run_window(17'd0, 17'd0, 100, 0, 200);
    run_window(17'd0, 17'd0, 100, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
